mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the I-cache and D-cache controllers.
- Both caches drive mem_req_type requests and expect mem_data_type responses. Each client holds valid until it sees ready.
- Grants one client at a time, using round-robin with a D-cache write-back lock so that write-back→allocate stays back-to-back.
- Sits between both cache FSMs and the memory model/controller.

Parameters:
- RR_INIT, 1: client preferred on the first contended arbitration after reset (0=I, 1=D).
- WB_LOCK, 1: 1 = after a D-cache write-back (rw=1) completes, hold the D grant for its next request.
- LOCK_WAIT, 2: cycles the WB lock waits for the D-cache to re-assert valid before releasing.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- ic_req  in  mem_req_type  I-cache request {addr[31:0], data[127:0], rw, valid}
- ic_res  out  mem_data_type  I-cache response {data[127:0], ready}
- dc_req  in  mem_req_type  D-cache request
- dc_res  out  mem_data_type  D-cache response
- mem_req  out  mem_req_type  request to memory
- mem_data  in  mem_data_type  memory response
- grant  out  2  one-hot {D,I} current owner; 00 = none
- proto_err  out  1  sticky: owner dropped valid before ready

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, grant=00, last_owner=~RR_INIT, lock counter=0, proto_err=0.
  - mem_req.valid=0, ic_res.ready=0, dc_res.ready=0.
- States: IDLE, OWN_I, OWN_D, WB_HOLD.
- IDLE:
  - Nothing valid → stay.
  - One valid → go OWN_x for that client.
  - Both valid → grant the client that is not last_owner.
  - Grant registers at the posedge. Memory first sees the request the cycle after the client raises valid (1-cycle arbitration latency).
- OWN_x:
  - mem_req is a combinational copy of the owner's request (addr, data, rw, valid).
  - The non-owner's request is ignored.
  - mem_data.data is broadcast to both res.data.
  - res.ready = mem_data.ready gated by ownership: non-owner ready is always 0.
- Completion (owner valid && mem_data.ready):
  - last_owner ← owner.
  - Owner is D, rw=1, and WB_LOCK=1 → WB_HOLD with counter=0.
  - Otherwise → IDLE (re-arbitrate next cycle; no back-to-back grant without passing IDLE).
- WB_HOLD:
  - grant stays D; mem_req.valid=0 until dc_req.valid.
  - dc_req.valid seen → OWN_D the same cycle (combinational pass-through; no IDLE bubble).
  - Otherwise the counter increments. At LOCK_WAIT with no D valid → IDLE.
  - I-cache requests wait.
- Protocol error: owner valid drops in OWN_x before ready → proto_err←1 (sticky until reset), state→IDLE, last_owner←owner.
- Simultaneous completion and a new request from the other client → completion wins; the other client is granted from IDLE next cycle.
- mem_data.ready while grant=00 is ignored, with no ready to either client.
- Reset mid-transaction drops the grant immediately. The memory side is assumed reset by the same reset.
- A D-cache request pulsed for one cycle (compare_tag) and then held (write_back/allocate) is a legal continuous request.

Optional Feature:
- Macro: MEM_PORT_ARBITER_PERF_EN.
- Defined:
  - Adds outputs perf_ic_grants[31:0], perf_dc_grants[31:0], perf_ic_wait[31:0], perf_dc_wait[31:0].
  - Grant counters increment on each completion for that client.
  - Wait counters increment each cycle that client is valid but not owner.
  - All four clear on reset and wrap at 2^32.
- Undefined: the outputs and counters do not exist. Functional behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, OWN_I, OWN_D, WB_HOLD}
  - client_e {CL_I=0, CL_D=1}
- mem_req_type and mem_data_type are reused from the existing shared interface header. Do not redefine them.
- Sub-module rr_pick2: combinational 2-way round-robin picker (valids, last_owner → one-hot pick). Everything else is inline.

Test Plan:
- Reset, then I-cache only, addr 0x100, rw=0; memory ready 3 cycles after request:
  - grant=01 one cycle after valid.
  - mem_req.addr=0x100.
  - ic_res.ready pulses once with data; dc_res.ready stays 0.
  - Back to IDLE.
- Both valid in the same cycle after reset, with RR_INIT=1:
  - D is granted first; I is granted after D completes.
  - A second simultaneous contention grants I, because last_owner=D.
- D write-back (rw=1, addr 0x2A0), then D allocate (rw=0, addr 0x4A0) with I waiting:
  - WB_HOLD is entered and D keeps the grant.
  - mem_req shows 0x2A0 then 0x4A0 before any I grant.
  - With WB_LOCK=0, I is granted between the two D requests.
- WB_HOLD with D silent for LOCK_WAIT=2 cycles and I valid:
  - Return to IDLE after 2 cycles; I is granted next.
- Owner I drops valid mid-transaction:
  - proto_err=1 and stays 1.
  - grant=00 next cycle.
  - proto_err clears only on reset=0.
- reset=0 asserted while OWN_D is waiting for ready:
  - Next cycle grant=00, mem_req.valid=0, all ready=0.
  - A ready pulse from memory in that cycle is not forwarded.
  - With PERF_EN, all counters read 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state and client encodings for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_I   = 2'd1,
    OWN_D   = 2'd2,
    WB_HOLD = 2'd3
  } arb_state_t;

  typedef enum logic {
    CL_I = 1'b0,
    CL_D = 1'b1
  } client_e;

endpackage

// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared cache <-> memory transaction types used by both cache
// controllers, the memory model and the port arbiter.
package mem_if_pkg;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker. On contention the client that did not
// own the port last wins; a single requester always wins.
module rr_pick2 (
  input  logic [1:0] i_valid,       // {D, I}
  input  logic       i_last_owner,  // 0 = I, 1 = D
  output logic [1:0] o_pick         // one-hot {D, I}, 00 = nobody
);

  // Pick the requester, alternating on contention.
  always_comb begin
    o_pick = 2'b00;
    unique case (i_valid)
      2'b01:   o_pick = 2'b01;
      2'b10:   o_pick = 2'b10;
      2'b11:   o_pick = i_last_owner ? 2'b01 : 2'b10;
      default: o_pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single main-memory port between the I-cache and
// D-cache controllers. Round-robin between clients; a completed D-cache
// write-back keeps the D grant for up to LOCK_WAIT cycles so the following
// allocate runs back-to-back. Optional performance counters are built when
// MEM_PORT_ARBITER_PERF_EN is defined.
module mem_port_arbiter
  import mem_if_pkg::*;
  import mem_arb_pkg::*;
#(
  parameter int unsigned RR_INIT   = 1,
  parameter int unsigned WB_LOCK   = 1,
  parameter int unsigned LOCK_WAIT = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  mem_req_type  ic_req,
  output mem_data_type ic_res,
  input  mem_req_type  dc_req,
  output mem_data_type dc_res,
  output mem_req_type  mem_req,
  input  mem_data_type mem_data,
  output logic [1:0]   grant,
  output logic         proto_err
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0]  perf_ic_grants,
  output logic [31:0]  perf_dc_grants,
  output logic [31:0]  perf_ic_wait,
  output logic [31:0]  perf_dc_wait
`endif
);

  localparam int unsigned CntW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) + 1 : 1;

  arb_state_t      r_state, w_state_next;
  client_e         r_last_owner, w_last_owner_next;
  logic [CntW-1:0] r_cnt, w_cnt_next;
  logic            r_proto_err, w_proto_err_next;
  logic [1:0]      w_pick;
  logic            w_own_i, w_own_d, w_d_active;

  rr_pick2 u_pick (
    .i_valid      ({dc_req.valid, ic_req.valid}),
    .i_last_owner (r_last_owner == CL_D),
    .o_pick       (w_pick)
  );

  // WB_HOLD counts as D ownership so a re-asserted D request passes straight
  // through without an IDLE bubble.
  assign w_own_i    = (r_state == OWN_I);
  assign w_own_d    = (r_state == OWN_D) || (r_state == WB_HOLD);
  assign w_d_active = (r_state == OWN_D) || ((r_state == WB_HOLD) && dc_req.valid);

  // Route the owner's request to memory and the memory response to the owner.
  always_comb begin
    mem_req = '0;
    if (w_own_i) begin
      mem_req = ic_req;
    end else if (w_own_d) begin
      mem_req = dc_req;
    end
    ic_res.data  = mem_data.data;
    ic_res.ready = mem_data.ready & w_own_i;
    dc_res.data  = mem_data.data;
    dc_res.ready = mem_data.ready & w_d_active;
    grant        = {w_own_d, w_own_i};
    proto_err    = r_proto_err;
  end

  // Next-state: arbitration, completion, write-back lock and protocol errors.
  always_comb begin
    w_state_next      = r_state;
    w_last_owner_next = r_last_owner;
    w_cnt_next        = r_cnt;
    w_proto_err_next  = r_proto_err;
    unique case (r_state)
      IDLE: begin
        if (w_pick[1]) begin
          w_state_next = OWN_D;
        end else if (w_pick[0]) begin
          w_state_next = OWN_I;
        end
      end
      OWN_I: begin
        if (!ic_req.valid) begin
          w_proto_err_next  = 1'b1;
          w_state_next      = IDLE;
          w_last_owner_next = CL_I;
        end else if (mem_data.ready) begin
          w_state_next      = IDLE;
          w_last_owner_next = CL_I;
        end
      end
      OWN_D, WB_HOLD: begin
        if (dc_req.valid) begin
          if (mem_data.ready) begin
            w_last_owner_next = CL_D;
            if (dc_req.rw && (WB_LOCK != 0)) begin
              w_state_next = WB_HOLD;
              w_cnt_next   = '0;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_state_next = OWN_D;
          end
        end else if (r_state == OWN_D) begin
          w_proto_err_next  = 1'b1;
          w_state_next      = IDLE;
          w_last_owner_next = CL_D;
        end else if ((32'(r_cnt) + 32'd1) >= LOCK_WAIT) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_last_owner <= (RR_INIT != 0) ? CL_I : CL_D;
      r_cnt        <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_last_owner <= w_last_owner_next;
      r_cnt        <= w_cnt_next;
      r_proto_err  <= w_proto_err_next;
    end
  end

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic        w_i_done, w_d_done;
  logic [31:0] r_ic_grants, r_dc_grants, r_ic_wait, r_dc_wait;

  assign w_i_done = w_own_i & ic_req.valid & mem_data.ready;
  assign w_d_done = w_d_active & mem_data.ready;

  // Completion and waiting-cycle counters; they wrap naturally.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ic_grants <= '0;
      r_dc_grants <= '0;
      r_ic_wait   <= '0;
      r_dc_wait   <= '0;
    end else begin
      r_ic_grants <= r_ic_grants + {31'd0, w_i_done};
      r_dc_grants <= r_dc_grants + {31'd0, w_d_done};
      r_ic_wait   <= r_ic_wait + {31'd0, ic_req.valid & ~w_own_i};
      r_dc_wait   <= r_dc_wait + {31'd0, dc_req.valid & ~w_own_d};
    end
  end

  assign perf_ic_grants = r_ic_grants;
  assign perf_dc_grants = r_dc_grants;
  assign perf_ic_wait   = r_ic_wait;
  assign perf_dc_wait   = r_dc_wait;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed per-cycle vector table, a WB_LOCK=0 sequence
// and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_if_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  mem_req_type  ic_req, dc_req, mem_req;
  mem_data_type ic_res, dc_res, mem_data;
  logic [1:0]   grant;
  logic         proto_err;

  mem_req_type  n_ic_req, n_dc_req, n_mem_req;
  mem_data_type n_ic_res, n_dc_res, n_mem_data;
  logic [1:0]   n_grant;
  logic         n_proto_err;

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] p_ig, p_dg, p_iw, p_dw, q_ig, q_dg, q_iw, q_dw;
`endif

  mem_port_arbiter #(.RR_INIT(1), .WB_LOCK(1), .LOCK_WAIT(2)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .ic_req    (ic_req),
    .ic_res    (ic_res),
    .dc_req    (dc_req),
    .dc_res    (dc_res),
    .mem_req   (mem_req),
    .mem_data  (mem_data),
    .grant     (grant),
    .proto_err (proto_err)
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    .perf_ic_grants (p_ig),
    .perf_dc_grants (p_dg),
    .perf_ic_wait   (p_iw),
    .perf_dc_wait   (p_dw)
`endif
  );

  mem_port_arbiter #(.RR_INIT(1), .WB_LOCK(0), .LOCK_WAIT(2)) u_nl (
    .clock     (clock),
    .reset     (reset),
    .ic_req    (n_ic_req),
    .ic_res    (n_ic_res),
    .dc_req    (n_dc_req),
    .dc_res    (n_dc_res),
    .mem_req   (n_mem_req),
    .mem_data  (n_mem_data),
    .grant     (n_grant),
    .proto_err (n_proto_err)
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    .perf_ic_grants (q_ig),
    .perf_dc_grants (q_dg),
    .perf_ic_wait   (q_iw),
    .perf_dc_wait   (q_dw)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus and expected outputs.
  typedef struct {
    string nm;
    int rst, iv, ia, dv, drw, da, mr;
    int chk, g, mv, ma, ir, dr, pe;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input int rst, input int iv, input int ia, input int dv,
                     input int drw, input int da, input int mr, input int chk, input int g,
                     input int mv, input int ma, input int ir, input int dr, input int pe);
    vec_t v;
    v.nm = nm; v.rst = rst; v.iv = iv; v.ia = ia; v.dv = dv; v.drw = drw; v.da = da;
    v.mr = mr; v.chk = chk; v.g = g; v.mv = mv; v.ma = ma; v.ir = ir; v.dr = dr; v.pe = pe;
    vecs.push_back(v);
  endtask

  // Random-phase model state.
  mem_req_type ic_cur, dc_cur;
  logic        ic_busy, dc_busy, issue_en;
  int          ic_iss, dc_iss, ic_done, dc_done;
  int          tb_last;  // 0 = I, 1 = D last completed
  logic [1:0]  prev_grant, exp_g;
  logic        prev_iv, prev_dv, wb_pend, exp_ir, exp_dr, exp_mv;
  int          mem_cnt, mem_tgt;

  initial begin
    ic_req = '0; dc_req = '0; mem_data = '0;
    n_ic_req = '0; n_dc_req = '0; n_mem_data = '0;
    reset = 1'b0;
    #1;

    // name        rst iv ia     dv rw da     mr  chk g  mv ma     ir dr pe
    add("rst0",     0, 0, 0,     0, 0, 0,     0,  0, 0, 0, 0,     0, 0, 0);
    add("rst1",     0, 0, 0,     0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 0);
    add("i_arb",    1, 1, 'h100, 0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 0);
    add("i_own1",   1, 1, 'h100, 0, 0, 0,     0,  1, 1, 1, 'h100, 0, 0, 0);
    add("i_own2",   1, 1, 'h100, 0, 0, 0,     0,  1, 1, 1, 'h100, 0, 0, 0);
    add("i_rdy",    1, 1, 'h100, 0, 0, 0,     1,  1, 1, 1, 'h100, 1, 0, 0);
    add("i_idle",   1, 0, 0,     0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 0);
    add("rr_rst",   0, 0, 0,     0, 0, 0,     0,  0, 0, 0, 0,     0, 0, 0);
    add("rr_arb",   1, 1, 'h200, 1, 0, 'h300, 0,  1, 0, 0, 0,     0, 0, 0);
    add("rr_d1",    1, 1, 'h200, 1, 0, 'h300, 0,  1, 2, 1, 'h300, 0, 0, 0);
    add("rr_d1rdy", 1, 1, 'h200, 1, 0, 'h300, 1,  1, 2, 1, 'h300, 0, 1, 0);
    add("rr_arb2",  1, 1, 'h200, 1, 0, 'h310, 0,  1, 0, 0, 0,     0, 0, 0);
    add("rr_i",     1, 1, 'h200, 1, 0, 'h310, 1,  1, 1, 1, 'h200, 1, 0, 0);
    add("rr_arb3",  1, 0, 0,     1, 0, 'h310, 0,  1, 0, 0, 0,     0, 0, 0);
    add("rr_d2",    1, 0, 0,     1, 0, 'h310, 1,  1, 2, 1, 'h310, 0, 1, 0);
    add("rr_idle",  1, 0, 0,     0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 0);
    add("wb_rst",   0, 0, 0,     0, 0, 0,     0,  0, 0, 0, 0,     0, 0, 0);
    add("wb_arb",   1, 1, 'h500, 1, 1, 'h2A0, 0,  1, 0, 0, 0,     0, 0, 0);
    add("wb_wr",    1, 1, 'h500, 1, 1, 'h2A0, 1,  1, 2, 1, 'h2A0, 0, 1, 0);
    add("wb_hold",  1, 1, 'h500, 0, 0, 0,     0,  1, 2, 0, 0,     0, 0, 0);
    add("wb_alloc", 1, 1, 'h500, 1, 0, 'h4A0, 0,  1, 2, 1, 'h4A0, 0, 0, 0);
    add("wb_ardy",  1, 1, 'h500, 1, 0, 'h4A0, 1,  1, 2, 1, 'h4A0, 0, 1, 0);
    add("wb_arbi",  1, 1, 'h500, 0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 0);
    add("wb_i",     1, 1, 'h500, 0, 0, 0,     1,  1, 1, 1, 'h500, 1, 0, 0);
    add("wb_idle",  1, 0, 0,     0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 0);
    add("to_rst",   0, 0, 0,     0, 0, 0,     0,  0, 0, 0, 0,     0, 0, 0);
    add("to_arb",   1, 1, 'h600, 1, 1, 'h2A0, 0,  1, 0, 0, 0,     0, 0, 0);
    add("to_wr",    1, 1, 'h600, 1, 1, 'h2A0, 1,  1, 2, 1, 'h2A0, 0, 1, 0);
    add("to_h0",    1, 1, 'h600, 0, 0, 0,     0,  1, 2, 0, 0,     0, 0, 0);
    add("to_h1",    1, 1, 'h600, 0, 0, 0,     0,  1, 2, 0, 0,     0, 0, 0);
    add("to_idle",  1, 1, 'h600, 0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 0);
    add("to_i",     1, 1, 'h600, 0, 0, 0,     1,  1, 1, 1, 'h600, 1, 0, 0);
    add("to_end",   1, 0, 0,     0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 0);
    add("pe_arb",   1, 1, 'h700, 0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 0);
    add("pe_own",   1, 1, 'h700, 0, 0, 0,     0,  1, 1, 1, 'h700, 0, 0, 0);
    add("pe_drop",  1, 0, 0,     0, 0, 0,     0,  1, 1, 0, 0,     0, 0, 0);
    add("pe_set",   1, 0, 0,     0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 1);
    add("pe_arb2",  1, 1, 'h710, 0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 1);
    add("pe_i",     1, 1, 'h710, 0, 0, 0,     1,  1, 1, 1, 'h710, 1, 0, 1);
    add("pe_stky",  1, 0, 0,     0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 1);
    add("pe_rst",   0, 0, 0,     0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 1);
    add("pe_clr",   1, 0, 0,     0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 0);
    add("rm_arb",   1, 0, 0,     1, 0, 'h800, 0,  1, 0, 0, 0,     0, 0, 0);
    add("rm_own",   1, 0, 0,     1, 0, 'h800, 0,  1, 2, 1, 'h800, 0, 0, 0);
    add("rm_rst",   0, 0, 0,     1, 0, 'h800, 0,  1, 2, 1, 'h800, 0, 0, 0);
    add("rm_after", 1, 0, 0,     1, 0, 'h800, 1,  1, 0, 0, 0,     0, 0, 0);
    add("rm_regrant",1,0, 0,     1, 0, 'h800, 1,  1, 2, 1, 'h800, 0, 1, 0);
    add("rm_idle",  1, 0, 0,     0, 0, 0,     0,  1, 0, 0, 0,     0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset         = vecs[i].rst[0];
      ic_req.addr   = 32'(vecs[i].ia);
      ic_req.data   = {4{32'(vecs[i].ia)}};
      ic_req.rw     = 1'b0;
      ic_req.valid  = vecs[i].iv[0];
      dc_req.addr   = 32'(vecs[i].da);
      dc_req.data   = {4{32'(vecs[i].da)}};
      dc_req.rw     = vecs[i].drw[0];
      dc_req.valid  = vecs[i].dv[0];
      mem_data.data = {4{32'(32'hA5A5_0000 + i)}};
      mem_data.ready = vecs[i].mr[0];
      #2;
      if (vecs[i].chk != 0) begin
        cmp({vecs[i].nm, "/grant"}, 128'(grant), 128'(vecs[i].g));
        cmp({vecs[i].nm, "/mem_valid"}, 128'(mem_req.valid), 128'(vecs[i].mv));
        if (vecs[i].mv != 0) cmp({vecs[i].nm, "/mem_addr"}, 128'(mem_req.addr), 128'(vecs[i].ma));
        cmp({vecs[i].nm, "/ic_ready"}, 128'(ic_res.ready), 128'(vecs[i].ir));
        cmp({vecs[i].nm, "/dc_ready"}, 128'(dc_res.ready), 128'(vecs[i].dr));
        cmp({vecs[i].nm, "/proto_err"}, 128'(proto_err), 128'(vecs[i].pe));
        if (vecs[i].ir != 0) cmp({vecs[i].nm, "/ic_data"}, ic_res.data, mem_data.data);
        if (vecs[i].dr != 0) cmp({vecs[i].nm, "/dc_data"}, dc_res.data, mem_data.data);
`ifdef MEM_PORT_ARBITER_PERF_EN
        if (vecs[i].nm == "rm_after") begin
          cmp("perf_zero", 128'({p_ig, p_dg, p_iw, p_dw}), 128'(0));
        end
`endif
      end
      @(posedge clock); #1;
    end

    // WB_LOCK=0 instance: I must be served between write-back and allocate.
    ic_req = '0; dc_req = '0; mem_data = '0;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    n_ic_req = '{addr: 32'h500, data: '0, rw: 1'b0, valid: 1'b1};
    n_dc_req = '{addr: 32'h2A0, data: '0, rw: 1'b1, valid: 1'b1};
    #2; cmp("nl_arb", 128'(n_grant), 128'(2'b00));
    @(posedge clock); #1;
    n_mem_data.ready = 1'b1;
    #2; cmp("nl_wb_grant", 128'(n_grant), 128'(2'b10));
    cmp("nl_wb_addr", 128'(n_mem_req.addr), 128'(32'h2A0));
    @(posedge clock); #1;
    n_mem_data.ready = 1'b0;
    n_dc_req.valid = 1'b0;
    #2; cmp("nl_no_hold", 128'(n_grant), 128'(2'b00));
    @(posedge clock); #1;
    n_dc_req = '{addr: 32'h4A0, data: '0, rw: 1'b0, valid: 1'b1};
    #2; cmp("nl_i_between", 128'(n_grant), 128'(2'b01));
    cmp("nl_i_addr", 128'(n_mem_req.addr), 128'(32'h500));
    @(posedge clock); #1;
    n_ic_req = '0; n_dc_req = '0;

    // Randomized run against a transaction-level model.
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    ic_busy = 1'b0; dc_busy = 1'b0; issue_en = 1'b1;
    ic_iss = 0; dc_iss = 0; ic_done = 0; dc_done = 0;
    tb_last = 0; prev_grant = 2'b00; prev_iv = 1'b0; prev_dv = 1'b0; wb_pend = 1'b0;
    mem_cnt = 0; mem_tgt = $urandom_range(0, 3);
    for (int cyc = 0; cyc < 3300; cyc++) begin
      if (cyc == 3000) issue_en = 1'b0;
      if (!issue_en && !ic_busy && !dc_busy && cyc > 3010) break;
      if (!ic_busy && issue_en && ($urandom_range(0, 2) == 0)) begin
        ic_busy = 1'b1; ic_iss++;
        ic_cur = '{addr: $urandom() & 32'hFFFF_FFF0,
                   data: {$urandom(), $urandom(), $urandom(), $urandom()},
                   rw: 1'b0, valid: 1'b1};
      end
      if (!dc_busy && issue_en && ($urandom_range(0, 2) == 0)) begin
        dc_busy = 1'b1; dc_iss++;
        dc_cur = '{addr: $urandom() & 32'hFFFF_FFF0,
                   data: {$urandom(), $urandom(), $urandom(), $urandom()},
                   rw: 1'($urandom_range(0, 1)), valid: 1'b1};
      end
      ic_req = ic_busy ? ic_cur : '0;
      dc_req = dc_busy ? dc_cur : '0;
      #1;
      mem_data.data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      mem_data.ready = 1'b0;
      if (mem_req.valid) begin
        if (mem_cnt >= mem_tgt) begin
          mem_data.ready = 1'b1;
          mem_cnt = 0;
          mem_tgt = $urandom_range(0, 3);
        end else begin
          mem_cnt++;
        end
      end else begin
        mem_cnt = 0;
      end
      #1;
      // Expected owner: from IDLE the rules pick; otherwise ownership persists.
      exp_g = grant;
      if (prev_grant == 2'b00) begin
        if (prev_iv && prev_dv) exp_g = (tb_last == 0) ? 2'b10 : 2'b01;
        else if (prev_dv)       exp_g = 2'b10;
        else if (prev_iv)       exp_g = 2'b01;
        else                    exp_g = 2'b00;
        cmp("rnd_arbitrate", 128'(grant), 128'(exp_g));
      end else if (wb_pend) begin
        exp_g = 2'b10;
        cmp("rnd_wb_lock", 128'(grant), 128'(exp_g));
      end
      cmp("rnd_no_swap", 128'((prev_grant == 2'b01 && grant == 2'b10) ||
                              (prev_grant == 2'b10 && grant == 2'b01) || grant == 2'b11),
          128'(0));
      exp_mv = (exp_g == 2'b01) ? ic_req.valid : (exp_g == 2'b10) ? dc_req.valid : 1'b0;
      cmp("rnd_mem_valid", 128'(mem_req.valid), 128'(exp_mv));
      if (exp_mv && exp_g == 2'b01) cmp("rnd_mem_req_i", 128'(mem_req), 128'(ic_req));
      if (exp_mv && exp_g == 2'b10) cmp("rnd_mem_req_d", 128'(mem_req), 128'(dc_req));
      exp_ir = mem_data.ready && (exp_g == 2'b01);
      exp_dr = mem_data.ready && (exp_g == 2'b10);
      cmp("rnd_ic_ready", 128'(ic_res.ready), 128'(exp_ir));
      cmp("rnd_dc_ready", 128'(dc_res.ready), 128'(exp_dr));
      cmp("rnd_ic_data", ic_res.data, mem_data.data);
      cmp("rnd_dc_data", dc_res.data, mem_data.data);
      cmp("rnd_proto_err", 128'(proto_err), 128'(0));
      wb_pend = 1'b0;
      if (exp_ir) begin
        ic_done++; ic_busy = 1'b0; tb_last = 0;
      end
      if (exp_dr) begin
        dc_done++; dc_busy = 1'b0; tb_last = 1; wb_pend = dc_cur.rw;
      end
      prev_grant = grant;
      prev_iv = ic_req.valid;
      prev_dv = dc_req.valid;
      @(posedge clock); #1;
    end
    cmp("rnd_drained", 128'({ic_busy, dc_busy}), 128'(0));
    cmp("rnd_ic_count", 128'(ic_done), 128'(ic_iss));
    cmp("rnd_dc_count", 128'(dc_done), 128'(dc_iss));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
